ln_stats_acc_gen: RTL and testbench
===================================

Name: ln_stats_acc_gen

Overview:
Parametrised per-pixel LayerNorm statistics engine for the Matrix/LN path. It consumes the channel-major feature stream returned by MCIF: TOUT signed lanes per beat, ceil(CH/TOUT) beats per pixel. For each pixel it produces the mean, the variance and a buffer write address for the stage-2 normaliser. Compared with the fixed-width stage-1 path, it adds:
- configurable lane count and data width
- partial-last-beat lane masking for CH not a multiple of TOUT
- output backpressure
- non-negative variance clamping

Parameters:
DW, 16, signed input element width
TOUT, 8, lanes per beat (power of 2)
CHB_W, 8, width of the beats-per-pixel count
RECIP_W, 17, width of the unsigned reciprocal round(2^16/CH)
PIX_W, 12, width of the pixel counter / write address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; latches the CSR fields and begins a frame
ch_div_tout  in  CHB_W  beats per pixel, 1..2^CHB_W-1
last_lane_mask  in  TOUT  valid-lane mask applied on the last beat of each pixel
pix_num  in  PIX_W  pixels per frame (h*w), 1..2^PIX_W-1
recip_ch  in  RECIP_W  round(65536/CH)
in_vld  in  1  input beat valid
in_rdy  out  1  input beat ready
in_pd  in  DW*TOUT  lane i = bits [i*DW +: DW], signed
out_vld  out  1  statistics valid
out_rdy  in  1  statistics accepted
mean  out  DW  signed mean
variance  out  2*DW+2  unsigned variance, clamped at or above 0
wr_addr  out  PIX_W  pixel index of the current result
busy  out  1  high from start until done
done  out  1  one-cycle pulse after the last pixel result is accepted

Behaviour:
- Reset: every register is 0, FSM in IDLE.
  - Outputs in_rdy, out_vld, busy and done are 0.
  - mean, variance and wr_addr are 0.
- start in IDLE:
  - Latch all CSR inputs.
  - Clear accumulators, beat count and pixel count.
  - Set busy; go to ACC.
  - start outside IDLE is ignored.
- FSM states: IDLE -> ACC -> MUL -> SUB -> OUT -> (ACC | FIN) -> IDLE.
- ACC:
  - in_rdy = 1.
  - Each beat where in_vld && in_rdy adds the lane sum to S and the lane square sum to Q.
  - S is signed, DW+log2(TOUT)+CHB_W bits. Q is unsigned, 2*DW+log2(TOUT)+CHB_W bits.
  - Lane reduction is combinational and happens in the same cycle as the handshake.
  - On the beat where beat_cnt == ch_div_tout-1, lanes with last_lane_mask[i]=0 contribute 0 to both sums; that beat moves the FSM to MUL.
  - On all other beats every lane contributes.
- MUL (1 cycle), computing from the completed sums:
  - m = (S*recip_ch) >>> 16, arithmetic shift (floor), truncated to DW with signed saturation.
  - e2 = (Q*recip_ch) >> 16.
  - Both results are registered.
- SUB (1 cycle): v = e2 - m*m, computed signed at 2*DW+3 bits. If v < 0 then variance = 0, else variance = v[2*DW+1:0].
  - Load mean, variance and wr_addr = pixel count.
  - Set out_vld.
- OUT:
  - Hold all outputs stable while out_vld && !out_rdy.
  - On acceptance: clear out_vld, clear accumulators and beat count, increment pixel count.
  - If the incremented count == pix_num, go to FIN; otherwise go to ACC.
- in_rdy is 0 in MUL, SUB, OUT and FIN. Input beats are never dropped or double-counted.
- Latency: last input beat accepted to out_vld = 2 cycles.
- FIN: pulse done for 1 cycle, clear busy, go to IDLE.
- ch_div_tout == 1: every beat is the last beat, so the mask applies on every beat.
- rst_n asserted mid-frame: immediate return to the reset state; no done pulse; partial sums are discarded.

Optional Feature:
LN_STATS_RMS_EN
- Defined: adds input port rms_mode (1 bit, latched on start). When rms_mode=1:
  - S accumulation is skipped.
  - mean is forced to 0.
  - variance = e2, giving RMSNorm statistics. Latency is unchanged.
  - When rms_mode=0, behaviour is identical to the undefined case.
- Undefined: no rms_mode port; LayerNorm statistics only.

Decomposition:
- Shared package/defines:
  - FSM state encoding (IDLE=0, ACC=1, MUL=2, SUB=3, OUT=4, FIN=5)
  - the reciprocal shift constant RECIP_SHIFT=16
  - derived accumulator width constants
- One sub-module, ln_lane_reduce: combinational masked lane sum and square sum over TOUT lanes. Instantiated once in ACC.

Test Plan:
Defaults throughout: TOUT=8, DW=16.
1. ch_div_tout=1, mask=8'hFF, recip=8192, pix_num=1, all lanes 3 -> mean=3, variance=0, wr_addr=0; done one cycle after acceptance.
2. Same config, lanes 1..8 -> S=36, Q=204, mean=4, e2=25, variance=9; out_vld exactly 2 cycles after the accepted beat.
3. Lanes {-1,0,0,0,0,0,0,0} -> mean=-1, e2=0, raw v=-1; variance clamped to 0.
4. ch_div_tout=2, mask=8'h0F, recip=5461 (CH=12): beat0 all 2, beat1 all 2 with upper lanes 100 -> masked lanes ignored; mean=1 (floor of 1.99), e2=3, variance=2.
5. pix_num=3, out_rdy low for 5 cycles on pixel 1 -> outputs stable, in_rdy=0 throughout the stall; wr_addr sequence 0,1,2; done exactly once.
6. rst_n pulsed mid-ACC of pixel 1, then start -> all outputs 0 after reset; new frame results unaffected by the partial sums.

Source files
------------

// File: rtl/ln_stats_acc_gen_pkg.sv
// rtl/ln_stats_acc_gen_pkg.sv - shared FSM encoding and width helpers for the LN statistics engine
package ln_stats_acc_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_MUL  = 3'd2,
        ST_SUB  = 3'd3,
        ST_OUT  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam int RECIP_SHIFT = 16;

    // Accumulator widths leave headroom for TOUT lanes times up to 2^chb_w beats.
    function automatic int acc_sum_w(input int dw, input int tout, input int chb_w);
        return dw + $clog2(tout) + chb_w;
    endfunction

    function automatic int acc_sq_w(input int dw, input int tout, input int chb_w);
        return 2 * dw + $clog2(tout) + chb_w;
    endfunction

endpackage

// File: rtl/ln_lane_reduce.sv
// rtl/ln_lane_reduce.sv - combinational masked lane sum and square sum over one beat
module ln_lane_reduce #(
    parameter int DW   = 16,
    parameter int TOUT = 8,
    localparam int LSW = DW + $clog2(TOUT),
    localparam int LQW = 2 * DW + $clog2(TOUT)
) (
    input  logic [DW*TOUT-1:0]    pd,
    input  logic [TOUT-1:0]       mask,
    output logic signed [LSW-1:0] lane_sum,
    output logic [LQW-1:0]        sq_sum
);

    logic signed [DW-1:0]   lane;
    logic signed [2*DW-1:0] sq;

    always_comb begin
        lane_sum = '0;
        sq_sum   = '0;
        lane     = '0;
        sq       = '0;
        for (int i = 0; i < TOUT; i++) begin
            if (mask[i]) begin
                lane     = $signed(pd[i*DW +: DW]);
                sq       = lane * lane;
                lane_sum = lane_sum + LSW'(lane);
                sq_sum   = sq_sum + LQW'($unsigned(sq));
            end
        end
    end

endmodule

// File: rtl/ln_stats_acc_gen.sv
// rtl/ln_stats_acc_gen.sv - per-pixel LayerNorm mean/variance engine; optional LN_STATS_RMS_EN adds RMSNorm mode
module ln_stats_acc_gen
    import ln_stats_acc_gen_pkg::*;
#(
    parameter int DW      = 16,
    parameter int TOUT    = 8,
    parameter int CHB_W   = 8,
    parameter int RECIP_W = 17,
    parameter int PIX_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHB_W-1:0]     ch_div_tout,
    input  logic [TOUT-1:0]      last_lane_mask,
    input  logic [PIX_W-1:0]     pix_num,
    input  logic [RECIP_W-1:0]   recip_ch,
`ifdef LN_STATS_RMS_EN
    input  logic                 rms_mode,
`endif
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [DW*TOUT-1:0]   in_pd,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic signed [DW-1:0] mean,
    output logic [2*DW+1:0]      variance,
    output logic [PIX_W-1:0]     wr_addr,
    output logic                 busy,
    output logic                 done
);

    localparam int LOG_T = $clog2(TOUT);
    localparam int SW    = acc_sum_w(DW, TOUT, CHB_W);
    localparam int QW    = acc_sq_w(DW, TOUT, CHB_W);
    localparam int LSW   = DW + LOG_T;
    localparam int LQW   = 2 * DW + LOG_T;
    localparam int VW    = 2 * DW + 2;
    localparam int VXW   = VW + 1;
    localparam int PW    = SW + RECIP_W + 1;
    localparam int EW    = QW + RECIP_W;

    state_t               state;
    logic [CHB_W-1:0]     chb_q;
    logic [TOUT-1:0]      mask_q;
    logic [PIX_W-1:0]     pix_num_q;
    logic [RECIP_W-1:0]   recip_q;
    logic [CHB_W-1:0]     beat_cnt;
    logic [PIX_W-1:0]     pix_cnt;
    logic signed [SW-1:0] s_acc;
    logic [QW-1:0]        q_acc;
    logic signed [DW-1:0] m_q;
    logic [VW-1:0]        e2_q;
    logic                 rms_on;

`ifdef LN_STATS_RMS_EN
    logic rms_q;
    assign rms_on = rms_q;
`else
    assign rms_on = 1'b0;
`endif

    logic                  last_beat;
    logic [TOUT-1:0]       lane_mask;
    logic signed [LSW-1:0] lane_sum;
    logic [LQW-1:0]        sq_sum;
    logic [PIX_W-1:0]      pix_next;

    assign last_beat = (beat_cnt == chb_q - CHB_W'(1));
    assign lane_mask = last_beat ? mask_q : '1;
    assign pix_next  = pix_cnt + PIX_W'(1);

    ln_lane_reduce #(
        .DW   (DW),
        .TOUT (TOUT)
    ) u_lane_reduce (
        .pd       (in_pd),
        .mask     (lane_mask),
        .lane_sum (lane_sum),
        .sq_sum   (sq_sum)
    );

    // Mean: floor division by CH via reciprocal, then signed saturation to DW.
    logic signed [PW-1:0] s_shift;
    logic signed [DW-1:0] m_sat;

    always_comb begin
        s_shift = (PW'(s_acc) * PW'($signed({1'b0, recip_q}))) >>> RECIP_SHIFT;
        if ((&s_shift[PW-1:DW-1]) || !(|s_shift[PW-1:DW-1]))
            m_sat = s_shift[DW-1:0];
        else
            m_sat = s_shift[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    logic signed [2*DW-1:0] m_sq;
    logic signed [VXW-1:0]  v_raw;
    logic [VW-1:0]          v_clamp;

    always_comb begin
        m_sq    = m_q * m_q;
        v_raw   = $signed({1'b0, e2_q}) - VXW'(m_sq);
        v_clamp = v_raw[VXW-1] ? '0 : v_raw[VW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            chb_q     <= '0;
            mask_q    <= '0;
            pix_num_q <= '0;
            recip_q   <= '0;
            beat_cnt  <= '0;
            pix_cnt   <= '0;
            s_acc     <= '0;
            q_acc     <= '0;
            m_q       <= '0;
            e2_q      <= '0;
            in_rdy    <= 1'b0;
            out_vld   <= 1'b0;
            mean      <= '0;
            variance  <= '0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef LN_STATS_RMS_EN
            rms_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        chb_q     <= ch_div_tout;
                        mask_q    <= last_lane_mask;
                        pix_num_q <= pix_num;
                        recip_q   <= recip_ch;
`ifdef LN_STATS_RMS_EN
                        rms_q     <= rms_mode;
`endif
                        s_acc     <= '0;
                        q_acc     <= '0;
                        beat_cnt  <= '0;
                        pix_cnt   <= '0;
                        busy      <= 1'b1;
                        in_rdy    <= 1'b1;
                        state     <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_vld && in_rdy) begin
                        if (!rms_on)
                            s_acc <= s_acc + SW'(lane_sum);
                        q_acc <= q_acc + QW'(sq_sum);
                        if (last_beat) begin
                            beat_cnt <= '0;
                            in_rdy   <= 1'b0;
                            state    <= ST_MUL;
                        end else begin
                            beat_cnt <= beat_cnt + CHB_W'(1);
                        end
                    end
                end
                ST_MUL: begin
                    m_q   <= m_sat;
                    e2_q  <= VW'((EW'(q_acc) * EW'(recip_q)) >> RECIP_SHIFT);
                    state <= ST_SUB;
                end
                ST_SUB: begin
                    mean     <= rms_on ? '0 : m_q;
                    variance <= rms_on ? e2_q : v_clamp;
                    wr_addr  <= pix_cnt;
                    out_vld  <= 1'b1;
                    state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_rdy) begin
                        out_vld  <= 1'b0;
                        s_acc    <= '0;
                        q_acc    <= '0;
                        beat_cnt <= '0;
                        pix_cnt  <= pix_next;
                        if (pix_next == pix_num_q) begin
                            state <= ST_FIN;
                        end else begin
                            in_rdy <= 1'b1;
                            state  <= ST_ACC;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ln_stats_acc_gen.sv
// tb/tb_ln_stats_acc_gen.sv - scoreboard bench for ln_stats_acc_gen with directed vectors
module tb_ln_stats_acc_gen;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [7:0]          ch_div_tout;
    logic [7:0]          last_lane_mask;
    logic [11:0]         pix_num;
    logic [16:0]         recip_ch;
    logic                in_vld;
    logic                in_rdy;
    logic [127:0]        in_pd;
    logic                out_vld;
    logic                out_rdy;
    logic signed [15:0]  mean;
    logic [33:0]         variance;
    logic [11:0]         wr_addr;
    logic                busy;
    logic                done;

    ln_stats_acc_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .ch_div_tout    (ch_div_tout),
        .last_lane_mask (last_lane_mask),
        .pix_num        (pix_num),
        .recip_ch       (recip_ch),
`ifdef LN_STATS_RMS_EN
        .rms_mode       (1'b0),
`endif
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_pd          (in_pd),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .mean           (mean),
        .variance       (variance),
        .wr_addr        (wr_addr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] m;
        logic [33:0]        v;
        logic [11:0]        a;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // Monitor: every cycle a result is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out wr_addr=%0d", wr_addr);
                end else begin
                    check("mean", 64'(mean), 64'(exp_q[0].m));
                    check("variance", 64'(variance), 64'(exp_q[0].v));
                    check("wr_addr", 64'(wr_addr), 64'(exp_q[0].a));
                    check("in_rdy_while_out", 64'(in_rdy), 64'd0);
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input int v, input int a);
        exp_t e;
        e.m = 16'(m);
        e.v = 34'(v);
        e.a = 12'(a);
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int chb, input int msk, input int pn, input int rc);
        ch_div_tout    = 8'(chb);
        last_lane_mask = 8'(msk);
        pix_num        = 12'(pn);
        recip_ch       = 17'(rc);
        start          = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] pd);
        int n = 0;
        in_pd  = pd;
        in_vld = 1'b1;
        while (!in_rdy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("in_rdy_timeout", 64'(in_rdy), 64'd1);
        tick();
        in_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("busy_timeout", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
        check({tag, "_out_vld"}, 64'(out_vld), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_mean"}, 64'(mean), 64'd0);
        check({tag, "_variance"}, 64'(variance), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        ch_div_tout = '0;
        last_lane_mask = '0;
        pix_num = '0;
        recip_ch = '0;
        in_vld = 1'b0;
        in_pd = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: constant lanes, zero variance, done timing
        d0 = done_cnt;
        do_start(1, 8'hFF, 1, 8192);
        push(3, 0, 0);
        send_beat(pk(3, 3, 3, 3, 3, 3, 3, 3));
        tick();
        tick();
        check("t1_out_vld", 64'(out_vld), 64'd1);
        tick();
        check("t1_done_early", 64'(done), 64'd0);
        tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy_clear", 64'(busy), 64'd0);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_done_count", 64'(done_cnt - d0), 64'd1);

        // 2: lanes 1..8, exact 2-cycle latency
        do_start(1, 8'hFF, 1, 8192);
        push(4, 9, 0);
        send_beat(pk(1, 2, 3, 4, 5, 6, 7, 8));
        check("t2_lat0", 64'(out_vld), 64'd0);
        tick();
        check("t2_lat1", 64'(out_vld), 64'd0);
        tick();
        check("t2_lat2", 64'(out_vld), 64'd1);
        wait_idle();

        // 3: negative raw variance clamps to 0
        do_start(1, 8'hFF, 1, 8192);
        push(-1, 0, 0);
        send_beat(pk(-1, 0, 0, 0, 0, 0, 0, 0));
        wait_idle();

        // 4: two beats, masked upper lanes on the last beat
        do_start(2, 8'h0F, 1, 5461);
        push(1, 2, 0);
        send_beat(pk(2, 2, 2, 2, 2, 2, 2, 2));
        send_beat(pk(2, 2, 2, 2, 100, 100, 100, 100));
        wait_idle();

        // 5: three pixels, output stall on pixel 1
        d0 = done_cnt;
        do_start(1, 8'hFF, 3, 8192);
        push(1, 0, 0);
        send_beat(pk(1, 1, 1, 1, 1, 1, 1, 1));
        push(4, 9, 1);
        send_beat(pk(1, 2, 3, 4, 5, 6, 7, 8));
        out_rdy = 1'b0;
        tick();
        tick();
        repeat (5) tick();
        check("t5_stall_vld", 64'(out_vld), 64'd1);
        check("t5_stall_addr", 64'(wr_addr), 64'd1);
        out_rdy = 1'b1;
        push(1, 1, 2);
        send_beat(pk(0, 2, 0, 2, 0, 2, 0, 2));
        wait_idle();
        check("t5_done_once", 64'(done_cnt - d0), 64'd1);

        // 6: reset mid-ACC of pixel 1, then a clean frame
        d0 = done_cnt;
        do_start(2, 8'h0F, 2, 5461);
        push(1, 2, 0);
        send_beat(pk(2, 2, 2, 2, 2, 2, 2, 2));
        send_beat(pk(2, 2, 2, 2, 100, 100, 100, 100));
        send_beat(pk(100, 100, 100, 100, 100, 100, 100, 100));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        do_start(2, 8'h0F, 1, 5461);
        push(1, 2, 0);
        send_beat(pk(2, 2, 2, 2, 2, 2, 2, 2));
        send_beat(pk(2, 2, 2, 2, 100, 100, 100, 100));
        wait_idle();
        check("t6_done_once", 64'(done_cnt - d0), 64'd1);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
